// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

    // Widest register address the shadow slots can hold; narrower ports are zero-extended.
    localparam int unsigned REG_AW_MAX = 8;

    typedef logic [REG_AW_MAX-1:0] RegAddr;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_M    = 2'b01,
        FWD_W    = 2'b10
    } FwdSel;

    // Shadow copy of one pipeline stage's register tags and control bits.
    typedef struct packed {
        logic   v;
        RegAddr rs;
        RegAddr rt;
        logic   use_rs;
        logic   use_rt;
        RegAddr dst;
        logic   wr;
        logic   ld;
        logic   st;
    } HazSlot;

endpackage

// File: rtl/hazard_fwd_ctrl_match.sv
// Slot-vs-register comparator: true when a valid writing slot targets register r.
module hazard_match
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter bit ZERO_HW = 1'b1
) (
    input  logic   v,
    input  logic   wr,
    input  RegAddr dst,
    input  RegAddr r,
    output logic   hit_c
);

    // Register 0 never matches when it is hardwired to zero.
    always_comb begin
        hit_c = v & wr & (dst == r) & ~(ZERO_HW & (r == '0));
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard-detection and forwarding controller for the 5-stage pipeline.
// Tracks X/M/W register tags in shadow slots and drives stall, bubble,
// flush and forward-select controls combinationally from those slots and D.
// Optional event counters are built when HAZARD_PERF_EN is defined.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter bit          FWD_EN  = 1'b1,
    parameter bit          ZERO_HW = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic              d_reg_write,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic              x_redirect,
    output logic              stall_if,
    output logic              stall_d,
    output logic              bubble_x,
    output logic              flush_d,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              fwd_mem_rt
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_flush,
    output logic [CNT_W-1:0]  perf_fwd
`endif
);

    HazSlot x_q, m_q, w_q;
    HazSlot d_slot_c;
    logic   hazard_c;

    logic hit_x_drs, hit_x_drt, hit_m_drs, hit_m_drt;
    logic hit_m_xrs, hit_m_xrt, hit_w_xrs, hit_w_xrt, hit_w_mrt;

    // Decode-stage fields packed into slot form for the X slot load.
    always_comb begin
        d_slot_c        = '0;
        d_slot_c.v      = d_valid;
        d_slot_c.rs     = RegAddr'(d_rs);
        d_slot_c.rt     = RegAddr'(d_rt);
        d_slot_c.use_rs = d_use_rs;
        d_slot_c.use_rt = d_use_rt;
        d_slot_c.dst    = RegAddr'(d_dst);
        d_slot_c.wr     = d_reg_write;
        d_slot_c.ld     = d_mem_read;
        d_slot_c.st     = d_mem_write;
    end

    // Shadow pipeline advance; a bubble drops the D instruction instead of loading it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= m_q;
            m_q <= x_q;
            x_q <= bubble_x ? HazSlot'('0) : d_slot_c;
        end
    end

    // W only needs its destination tag and load flag.
    logic unused_w;
    assign unused_w = ^{w_q.rs, w_q.rt, w_q.use_rs, w_q.use_rt, w_q.st};

    hazard_match #(.ZERO_HW(ZERO_HW)) u_x_drs (.v(x_q.v), .wr(x_q.wr), .dst(x_q.dst), .r(d_slot_c.rs), .hit_c(hit_x_drs));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_x_drt (.v(x_q.v), .wr(x_q.wr), .dst(x_q.dst), .r(d_slot_c.rt), .hit_c(hit_x_drt));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_m_drs (.v(m_q.v), .wr(m_q.wr), .dst(m_q.dst), .r(d_slot_c.rs), .hit_c(hit_m_drs));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_m_drt (.v(m_q.v), .wr(m_q.wr), .dst(m_q.dst), .r(d_slot_c.rt), .hit_c(hit_m_drt));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_m_xrs (.v(m_q.v), .wr(m_q.wr), .dst(m_q.dst), .r(x_q.rs),      .hit_c(hit_m_xrs));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_m_xrt (.v(m_q.v), .wr(m_q.wr), .dst(m_q.dst), .r(x_q.rt),      .hit_c(hit_m_xrt));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_w_xrs (.v(w_q.v), .wr(w_q.wr), .dst(w_q.dst), .r(x_q.rs),      .hit_c(hit_w_xrs));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_w_xrt (.v(w_q.v), .wr(w_q.wr), .dst(w_q.dst), .r(x_q.rt),      .hit_c(hit_w_xrt));
    hazard_match #(.ZERO_HW(ZERO_HW)) u_w_mrt (.v(w_q.v), .wr(w_q.wr), .dst(w_q.dst), .r(m_q.rt),      .hit_c(hit_w_mrt));

    // Stall/bubble/flush and forward-select decode; redirect wins over any stall.
    always_comb begin
        hazard_c   = 1'b0;
        stall_if   = 1'b0;
        stall_d    = 1'b0;
        bubble_x   = 1'b0;
        flush_d    = 1'b0;
        fwd_rs_sel = FWD_NONE;
        fwd_rt_sel = FWD_NONE;
        fwd_mem_rt = 1'b0;

        if (d_valid) begin
            if (FWD_EN) begin
                // A store needing only its data from the load picks it up later in M.
                hazard_c = x_q.ld & ((d_use_rs & hit_x_drs) |
                                     (d_use_rt & hit_x_drt & ~d_mem_write));
            end else begin
                hazard_c = (d_use_rs & (hit_x_drs | hit_m_drs)) |
                           (d_use_rt & (hit_x_drt | hit_m_drt));
            end
        end

        flush_d  = x_redirect;
        bubble_x = x_redirect | hazard_c;
        stall_if = hazard_c & ~x_redirect;
        stall_d  = hazard_c & ~x_redirect;

        if (FWD_EN && x_q.v) begin
            if (x_q.use_rs & hit_m_xrs)      fwd_rs_sel = FWD_M;
            else if (hit_w_xrs)              fwd_rs_sel = FWD_W;
            if (x_q.use_rt & hit_m_xrt)      fwd_rt_sel = FWD_M;
            else if (hit_w_xrt)              fwd_rt_sel = FWD_W;
        end

        if (FWD_EN) begin
            fwd_mem_rt = m_q.v & m_q.st & hit_w_mrt & w_q.ld;
        end
    end

`ifdef HAZARD_PERF_EN
    logic fwd_any_c;

    always_comb begin
        fwd_any_c = (fwd_rs_sel != 2'b00) | (fwd_rt_sel != 2'b00) | fwd_mem_rt;
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_fwd   <= '0;
        end else begin
            if (stall_d && (perf_stall != '1))    perf_stall <= perf_stall + CNT_W'(1);
            if (x_redirect && (perf_flush != '1)) perf_flush <= perf_flush + CNT_W'(1);
            if (fwd_any_c && (perf_fwd != '1))    perf_fwd   <= perf_fwd + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^CNT_W;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: one forwarding and one stall-only instance share stimulus.
module tb_hazard_fwd_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_valid, d_use_rs, d_use_rt, d_reg_write, d_mem_read, d_mem_write, x_redirect;
    logic [AW-1:0] d_rs, d_rt, d_dst;

    logic          stall_if_o [2];
    logic          stall_d_o  [2];
    logic          bubble_x_o [2];
    logic          flush_d_o  [2];
    logic [1:0]    fwd_rs_o   [2];
    logic [1:0]    fwd_rt_o   [2];
    logic          fwd_mem_o  [2];
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] perf_stall_o [2];
    logic [CW-1:0] perf_flush_o [2];
    logic [CW-1:0] perf_fwd_o   [2];
`endif

    int n_run  = 0;
    int n_fail = 0;
    bit model_ready = 1'b0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(AW), .FWD_EN(1'b1), .ZERO_HW(1'b1), .CNT_W(CW)) u_fwd (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_dst(d_dst), .d_reg_write(d_reg_write),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .x_redirect(x_redirect),
        .stall_if(stall_if_o[1]), .stall_d(stall_d_o[1]), .bubble_x(bubble_x_o[1]),
        .flush_d(flush_d_o[1]), .fwd_rs_sel(fwd_rs_o[1]), .fwd_rt_sel(fwd_rt_o[1]),
        .fwd_mem_rt(fwd_mem_o[1])
`ifdef HAZARD_PERF_EN
        , .perf_stall(perf_stall_o[1]), .perf_flush(perf_flush_o[1]), .perf_fwd(perf_fwd_o[1])
`endif
    );

    hazard_fwd_ctrl #(.REG_AW(AW), .FWD_EN(1'b0), .ZERO_HW(1'b1), .CNT_W(CW)) u_nofwd (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_dst(d_dst), .d_reg_write(d_reg_write),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .x_redirect(x_redirect),
        .stall_if(stall_if_o[0]), .stall_d(stall_d_o[0]), .bubble_x(bubble_x_o[0]),
        .flush_d(flush_d_o[0]), .fwd_rs_sel(fwd_rs_o[0]), .fwd_rt_sel(fwd_rt_o[0]),
        .fwd_mem_rt(fwd_mem_o[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall(perf_stall_o[0]), .perf_flush(perf_flush_o[0]), .perf_fwd(perf_fwd_o[0])
`endif
    );

    // ---------------- reference model: an instruction list per stage ----------------
    typedef struct {
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        int dst;
        bit wr;
        bit ld;
        bit st;
    } ins_t;

    typedef struct {
        bit stall;
        bit bubble;
        bit flush;
        int frs;
        int frt;
        bit fmem;
    } exp_t;

    ins_t mx [2];
    ins_t mm [2];
    ins_t mw [2];
    int   pc_stall [2];
    int   pc_flush [2];
    int   pc_fwd   [2];

    function automatic ins_t nop_ins();
        ins_t n;
        n.v = 0; n.rs = 0; n.rt = 0; n.urs = 0; n.urt = 0;
        n.dst = 0; n.wr = 0; n.ld = 0; n.st = 0;
        return n;
    endfunction

    function automatic ins_t cur_d();
        ins_t n;
        n.v = d_valid; n.rs = int'(d_rs); n.rt = int'(d_rt);
        n.urs = d_use_rs; n.urt = d_use_rt; n.dst = int'(d_dst);
        n.wr = d_reg_write; n.ld = d_mem_read; n.st = d_mem_write;
        return n;
    endfunction

    // Does the instruction in stage s produce register r (r0 is constant zero)?
    function automatic bit produces(input ins_t s, input int r);
        return s.v && s.wr && (s.dst == r) && (r != 0);
    endfunction

    function automatic exp_t predict(input bit fe, input ins_t x, input ins_t m,
                                     input ins_t w, input ins_t d, input bit redir);
        exp_t e;
        bit   hz;
        hz = 0;
        e.stall = 0; e.bubble = 0; e.flush = 0; e.frs = 0; e.frt = 0; e.fmem = 0;
        if (d.v) begin
            if (fe)
                hz = x.ld && ((d.urs && produces(x, d.rs)) ||
                              (d.urt && produces(x, d.rt) && !d.st));
            else
                hz = (d.urs && (produces(x, d.rs) || produces(m, d.rs))) ||
                     (d.urt && (produces(x, d.rt) || produces(m, d.rt)));
        end
        e.flush  = redir;
        e.bubble = redir || hz;
        e.stall  = hz && !redir;
        if (fe && x.v) begin
            if (x.urs && produces(m, x.rs))      e.frs = 1;
            else if (produces(w, x.rs))          e.frs = 2;
            if (x.urt && produces(m, x.rt))      e.frt = 1;
            else if (produces(w, x.rt))          e.frt = 2;
        end
        if (fe) e.fmem = m.v && m.st && produces(w, m.rt) && w.ld;
        return e;
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model advance at each clock edge.
    always @(posedge clk) begin
        exp_t e;
        ins_t d;
        d = cur_d();
        for (int k = 0; k < 2; k++) begin
            e = predict(k == 1, mx[k], mm[k], mw[k], d, x_redirect);
            if (!rst) begin
                mx[k] = nop_ins(); mm[k] = nop_ins(); mw[k] = nop_ins();
                pc_stall[k] = 0; pc_flush[k] = 0; pc_fwd[k] = 0;
            end else begin
                if (e.stall && pc_stall[k] < (2**CW - 1)) pc_stall[k]++;
                if (e.flush && pc_flush[k] < (2**CW - 1)) pc_flush[k]++;
                if ((e.frs != 0 || e.frt != 0 || e.fmem) && pc_fwd[k] < (2**CW - 1)) pc_fwd[k]++;
                mw[k] = mm[k];
                mm[k] = mx[k];
                mx[k] = e.bubble ? nop_ins() : d;
            end
        end
        if (!rst) model_ready = 1'b1;
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t e;
        if (model_ready) begin
            for (int k = 0; k < 2; k++) begin
                e = predict(k == 1, mx[k], mm[k], mw[k], cur_d(), x_redirect);
                chk("stall_if",   k, int'(stall_if_o[k]), int'(e.stall));
                chk("stall_d",    k, int'(stall_d_o[k]),  int'(e.stall));
                chk("bubble_x",   k, int'(bubble_x_o[k]), int'(e.bubble));
                chk("flush_d",    k, int'(flush_d_o[k]),  int'(e.flush));
                chk("fwd_rs_sel", k, int'(fwd_rs_o[k]),   e.frs);
                chk("fwd_rt_sel", k, int'(fwd_rt_o[k]),   e.frt);
                chk("fwd_mem_rt", k, int'(fwd_mem_o[k]),  int'(e.fmem));
`ifdef HAZARD_PERF_EN
                chk("perf_stall", k, int'(perf_stall_o[k]), pc_stall[k]);
                chk("perf_flush", k, int'(perf_flush_o[k]), pc_flush[k]);
                chk("perf_fwd",   k, int'(perf_fwd_o[k]),   pc_fwd[k]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int dst, input bit wr, input bit ld, input bit st, input bit redir);
        d_valid     = v;
        d_rs        = AW'(rs);
        d_rt        = AW'(rt);
        d_use_rs    = urs;
        d_use_rt    = urt;
        d_dst       = AW'(dst);
        d_reg_write = wr;
        d_mem_read  = ld;
        d_mem_write = st;
        x_redirect  = redir;
    endtask

    task automatic nop_drive();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cyc();
            nop_drive();
        end
    endtask

    initial begin
        rst = 1'b0;
        nop_drive();
        next_cyc();
        next_cyc();
        settle();
        chk("reset_stall_d",  1, int'(stall_d_o[1]),  0);
        chk("reset_bubble_x", 1, int'(bubble_x_o[1]), 0);
        chk("reset_fwd_rs",   1, int'(fwd_rs_o[1]),   0);
        chk("reset_fwd_mem",  1, int'(fwd_mem_o[1]),  0);
        rst = 1'b1;

        // lw $2 ; add $3,$2,$4 : one load-use stall then W forward
        next_cyc(); drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0); settle();
        chk("t1_no_stall_first", 1, int'(stall_d_o[1]), 0);
        next_cyc(); drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0); settle();
        chk("t1_stall_if",  1, int'(stall_if_o[1]), 1);
        chk("t1_stall_d",   1, int'(stall_d_o[1]),  1);
        chk("t1_bubble_x",  1, int'(bubble_x_o[1]), 1);
        next_cyc(); drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0); settle();
        chk("t1_stall_released", 1, int'(stall_d_o[1]), 0);
        next_cyc(); nop_drive(); settle();
        chk("t1_fwd_rs_w", 1, int'(fwd_rs_o[1]), 2);
        chk("t1_fwd_rt_0", 1, int'(fwd_rt_o[1]), 0);
        idle(3);

        // add $5 ; sub $6,$5,$5 : M forward on both operands
        next_cyc(); drive(1, 1, 4, 1, 1, 5, 1, 0, 0, 0);
        next_cyc(); drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 0); settle();
        chk("t2_no_stall", 1, int'(stall_d_o[1]), 0);
        next_cyc(); nop_drive(); settle();
        chk("t2_fwd_rs_m", 1, int'(fwd_rs_o[1]), 1);
        chk("t2_fwd_rt_m", 1, int'(fwd_rt_o[1]), 1);
        idle(3);

        // lw $7 ; sw $7,0($1) : no stall, store data forwarded in M
        next_cyc(); drive(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
        next_cyc(); drive(1, 1, 7, 1, 1, 0, 0, 0, 1, 0); settle();
        chk("t3_no_stall",  1, int'(stall_d_o[1]),  0);
        chk("t3_no_bubble", 1, int'(bubble_x_o[1]), 0);
        next_cyc(); nop_drive();
        next_cyc(); nop_drive(); settle();
        chk("t3_fwd_mem_rt", 1, int'(fwd_mem_o[1]), 1);
        idle(3);

        // no-forward build: add $5 ; or $8,$5,$0 stalls two cycles
        next_cyc(); drive(1, 1, 4, 1, 1, 5, 1, 0, 0, 0);
        next_cyc(); drive(1, 5, 0, 1, 1, 8, 1, 0, 0, 0); settle();
        chk("t4_stall_c1",  0, int'(stall_d_o[0]),  1);
        chk("t4_bubble_c1", 0, int'(bubble_x_o[0]), 1);
        chk("t4_fwd_rs_0",  0, int'(fwd_rs_o[0]),   0);
        next_cyc(); drive(1, 5, 0, 1, 1, 8, 1, 0, 0, 0); settle();
        chk("t4_stall_c2",  0, int'(stall_d_o[0]),  1);
        next_cyc(); drive(1, 5, 0, 1, 1, 8, 1, 0, 0, 0); settle();
        chk("t4_stall_done", 0, int'(stall_d_o[0]), 0);
        idle(3);

        // redirect over a load-use, then $0 producer causes nothing
        next_cyc(); drive(1, 1, 0, 1, 0, 9, 1, 1, 0, 0);
        next_cyc(); drive(1, 9, 4, 1, 1, 10, 1, 0, 0, 1); settle();
        chk("t5_flush_d",  1, int'(flush_d_o[1]),  1);
        chk("t5_bubble_x", 1, int'(bubble_x_o[1]), 1);
        chk("t5_stall_if", 1, int'(stall_if_o[1]), 0);
        chk("t5_stall_d",  1, int'(stall_d_o[1]),  0);
        next_cyc(); drive(1, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        next_cyc(); drive(1, 0, 0, 1, 1, 11, 1, 0, 0, 0); settle();
        chk("t5_zero_reg_nofwd", 0, int'(stall_d_o[0]), 0);
        chk("t5_zero_reg_fwd",   1, int'(stall_d_o[1]), 0);
        idle(3);

        // reset asserted while a load-use stall is pending
        next_cyc(); drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
        next_cyc(); drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0); rst = 1'b0; settle();
        chk("t6_stall_before_rst", 1, int'(stall_d_o[1]), 1);
        next_cyc(); nop_drive(); settle();
        chk("t6_stall_if",  1, int'(stall_if_o[1]), 0);
        chk("t6_stall_d",   1, int'(stall_d_o[1]),  0);
        chk("t6_bubble_x",  1, int'(bubble_x_o[1]), 0);
        chk("t6_flush_d",   1, int'(flush_d_o[1]),  0);
        chk("t6_fwd_rs",    1, int'(fwd_rs_o[1]),   0);
        chk("t6_fwd_rt",    1, int'(fwd_rt_o[1]),   0);
        chk("t6_fwd_mem",   1, int'(fwd_mem_o[1]),  0);
`ifdef HAZARD_PERF_EN
        chk("t6_perf_stall", 1, int'(perf_stall_o[1]), 0);
        chk("t6_perf_flush", 1, int'(perf_flush_o[1]), 0);
        chk("t6_perf_fwd",   1, int'(perf_fwd_o[1]),   0);
`endif
        rst = 1'b1;

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            next_cyc();
            rst = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0);
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
